// File: rtl/chroma_upsampler_pkg.sv
// rtl/chroma_upsampler_pkg.sv - shared types, sizes and beat-count helper for the chroma upsampler
package jpeg_upsample_pkg;

  localparam int PIX_W = 8;
  localparam int BLK   = 8;
  localparam int CH    = 3;
  localparam int CH_W  = $clog2(CH + 1);
  localparam int H     = BLK / 2;
  localparam int IDX_W = $clog2(BLK);

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [BLK-1:0][BLK-1:0] block_t;

  typedef enum logic [1:0] {SAMP_444, SAMP_422, SAMP_420, SAMP_RSVD} samp_mode_t;
  typedef enum logic {UPS_IDLE, UPS_EMIT} ups_state_t;

  // Only subsampled chroma (Cb/Cr) expands; luma, 4:4:4, reserved and ch 3 emit one beat.
  function automatic logic [2:0] beats_for(input logic [CH_W-1:0] ch, input samp_mode_t mode);
    logic [2:0] n;
    n = 3'd1;
    if (ch == CH_W'(1) || ch == CH_W'(2)) begin
      case (mode)
        SAMP_422: n = 3'd2;
        SAMP_420: n = 3'd4;
        default:  n = 3'd1;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/chroma_upsampler_if.sv
// rtl/chroma_upsampler_if.sv - block-in / beat-out handshake bundle of the chroma upsampler
interface chroma_upsampler_if;
  import jpeg_upsample_pkg::*;

  logic              valid_in;
  logic              ready_in;
  logic [CH_W-1:0]   ch;
  logic [1:0]        mode;
  block_t            block_in;
  logic              valid_out;
  logic              ready_out;
  block_t            block_out;
  logic [CH_W-1:0]   ch_out;
  logic [1:0]        idx_out;
  logic              last_out;

  modport master (
    output valid_in, ch, mode, block_in, ready_out,
    input  ready_in, valid_out, block_out, ch_out, idx_out, last_out
  );

  modport slave (
    input  valid_in, ch, mode, block_in, ready_out,
    output ready_in, valid_out, block_out, ch_out, idx_out, last_out
  );

endinterface

// File: rtl/chroma_upsampler_map.sv
// rtl/chroma_upsampler_map.sv - combinational nearest-neighbour sub-block selection
module upsample_map
  import jpeg_upsample_pkg::*;
(
  input  block_t     src,
  input  samp_mode_t mode,
  input  logic [2:0] n,
  input  logic [1:0] beat,
  output block_t     blk
);

  int row_base;
  int col_base;

  // Pick the quadrant/half for this beat and replicate each source sample 2x per axis.
  always_comb begin
    blk      = src;
    row_base = beat[1] ? H : 0;
    col_base = beat[0] ? H : 0;
    for (int i = 0; i < BLK; i++) begin
      for (int j = 0; j < BLK; j++) begin
        if (n == 3'd4 && mode == SAMP_420) begin
          blk[i][j] = src[IDX_W'(row_base + i / 2)][IDX_W'(col_base + j / 2)];
        end else if (n == 3'd2 && mode == SAMP_422) begin
          blk[i][j] = src[i][IDX_W'(col_base + j / 2)];
        end
      end
    end
  end

endmodule

// File: rtl/chroma_upsampler.sv
// rtl/chroma_upsampler.sv - registers one component block and streams its upsampled beats
module chroma_upsampler
  import jpeg_upsample_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  chroma_upsampler_if.slave  bus
);

  ups_state_t      state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  block_t          src_q, src_d;
  logic [CH_W-1:0] ch_q, ch_d;
  samp_mode_t      mode_q, mode_d;
  logic [2:0]      n_q, n_d;
  logic            last_beat;
  logic            accept;
  block_t          mapped;

  assign last_beat = (state_q == UPS_EMIT) && ({1'b0, beat_q} == (n_q - 3'd1));

  upsample_map u_map (
    .src  (src_q),
    .mode (mode_q),
    .n    (n_q),
    .beat (beat_q),
    .blk  (mapped)
  );

  // State and source registers; reset discards any partially emitted block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UPS_IDLE;
      beat_q  <= 2'd0;
      src_q   <= '0;
      ch_q    <= '0;
      mode_q  <= SAMP_444;
      n_q     <= 3'd1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      src_q   <= src_d;
      ch_q    <= ch_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
    end
  end

  // Next state: advance beats on handshake, recapture on the last beat for bubble-free flow.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    src_d   = src_q;
    ch_d    = ch_q;
    mode_d  = mode_q;
    n_d     = n_q;
    accept  = bus.valid_in && ((state_q == UPS_IDLE) || (last_beat && bus.ready_out));
    case (state_q)
      UPS_IDLE: begin
        if (accept) state_d = UPS_EMIT;
      end
      UPS_EMIT: begin
        if (bus.ready_out) begin
          if (!last_beat) begin
            beat_d = beat_q + 2'd1;
          end else if (!accept) begin
            state_d = UPS_IDLE;
            beat_d  = 2'd0;
          end
        end
      end
      default: state_d = UPS_IDLE;
    endcase
    if (accept) begin
      src_d  = bus.block_in;
      ch_d   = bus.ch;
      mode_d = samp_mode_t'(bus.mode);
      n_d    = beats_for(bus.ch, samp_mode_t'(bus.mode));
      beat_d = 2'd0;
    end
  end

  // Outputs are pure functions of the registered state, so they hold steady under stall.
  always_comb begin
    bus.valid_out = (state_q == UPS_EMIT);
    bus.last_out  = last_beat;
    bus.idx_out   = beat_q;
    bus.ch_out    = ch_q;
    bus.block_out = mapped;
    bus.ready_in  = (state_q == UPS_IDLE) || (last_beat && bus.ready_out);
  end

endmodule

// File: tb/tb_chroma_upsampler.sv
// tb/tb_chroma_upsampler.sv - directed self-checking bench for chroma_upsampler
module tb_chroma_upsampler;
  import jpeg_upsample_pkg::*;

  localparam int W = PIX_W * BLK * BLK;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  chroma_upsampler_if u_if ();

  chroma_upsampler dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  int     n_chk = 0;
  int     n_pass = 0;
  block_t ramp;
  block_t ramp2;
  block_t held;
  block_t seen [4];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic block_t exp_blk(input block_t b, input int n, input int k);
    block_t o;
    for (int i = 0; i < BLK; i++) begin
      for (int j = 0; j < BLK; j++) begin
        if (n == 1)      o[i][j] = b[i][j];
        else if (n == 2) o[i][j] = b[i][k * H + j / 2];
        else             o[i][j] = b[(k / 2) * H + i / 2][(k % 2) * H + j / 2];
      end
    end
    return o;
  endfunction

  task automatic offer(input logic [CH_W-1:0] c, input logic [1:0] m, input block_t b);
    u_if.valid_in = 1'b1;
    u_if.ch       = c;
    u_if.mode     = m;
    u_if.block_in = b;
  endtask

  task automatic run_block(input logic [CH_W-1:0] c, input logic [1:0] m, input block_t b, input int n);
    @(negedge clock);
    offer(c, m, b);
    u_if.ready_out = 1'b1;
    #1;
    chk("ready_in_idle", W'(u_if.ready_in), W'(1'b1));
    chk("valid_out_idle", W'(u_if.valid_out), W'(1'b0));
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      u_if.valid_in = 1'b0;
      #1;
      chk($sformatf("valid_b%0d", k), W'(u_if.valid_out), W'(1'b1));
      chk($sformatf("idx_b%0d", k), W'(u_if.idx_out), W'(k));
      chk($sformatf("last_b%0d", k), W'(u_if.last_out), W'(k == n - 1));
      chk($sformatf("ch_b%0d", k), W'(u_if.ch_out), W'(c));
      chk($sformatf("blk_b%0d", k), u_if.block_out, exp_blk(b, n, k));
      if (k < 4) seen[k] = u_if.block_out;
    end
    @(negedge clock);
    #1;
    chk("back_to_idle", W'(u_if.valid_out), W'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int xfers;
    int k;
    int cyc;
    logic prev_stall;
    logic [1:0] held_idx;

    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++) begin
        ramp[i][j]  = PIX_W'(8 * i + j);
        ramp2[i][j] = PIX_W'(8 * i + j + 100);
      end
    u_if.valid_in  = 1'b0;
    u_if.ready_out = 1'b0;
    u_if.ch        = '0;
    u_if.mode      = 2'd0;
    u_if.block_in  = '0;

    // reset values
    #2;
    chk("rst_valid_out", W'(u_if.valid_out), W'(1'b0));
    chk("rst_ready_in", W'(u_if.ready_in), W'(1'b1));
    chk("rst_last_out", W'(u_if.last_out), W'(1'b0));
    chk("rst_idx_out", W'(u_if.idx_out), W'(2'd0));
    chk("rst_ch_out", W'(u_if.ch_out), W'(2'd0));
    chk("rst_block_out", u_if.block_out, W'(0));
    @(negedge clock);
    reset_n = 1'b1;

    // luma passes straight through even in 4:2:0
    run_block(2'd0, 2'd2, ramp, 1);
    chk("y_passthru", seen[0], ramp);

    // Cb 4:2:0, four quadrants
    run_block(2'd1, 2'd2, ramp, 4);
    chk("cb420_b0_00", W'(seen[0][0][0]), W'(0));
    chk("cb420_b0_11", W'(seen[0][1][1]), W'(0));
    chk("cb420_b0_77", W'(seen[0][7][7]), W'(27));
    chk("cb420_b3_00", W'(seen[3][0][0]), W'(36));
    chk("cb420_b3_77", W'(seen[3][7][7]), W'(63));

    // Cr 4:2:2, two halves
    run_block(2'd2, 2'd1, ramp, 2);
    chk("cr422_b0_57", W'(seen[0][5][7]), W'(43));
    chk("cr422_b1_57", W'(seen[1][5][7]), W'(47));

    // single-beat corner cases: ch 3, reserved mode, 4:4:4 chroma
    run_block(2'd3, 2'd2, ramp, 1);
    run_block(2'd1, 2'd3, ramp2, 1);
    run_block(2'd2, 2'd0, ramp, 1);

    // stall pattern 1,0,0,1 repeating
    @(negedge clock);
    offer(2'd1, 2'd2, ramp);
    u_if.ready_out = 1'b0;
    #1;
    xfers = 0;
    k = 0;
    cyc = 0;
    prev_stall = 1'b0;
    held_idx = 2'd0;
    while (xfers < 4 && cyc < 40) begin
      @(negedge clock);
      u_if.valid_in  = 1'b0;
      u_if.ready_out = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      chk("stall_valid", W'(u_if.valid_out), W'(1'b1));
      chk("stall_idx", W'(u_if.idx_out), W'(k));
      chk("stall_blk", u_if.block_out, exp_blk(ramp, 4, k));
      chk("stall_ready_in", W'(u_if.ready_in), W'(u_if.ready_out && k == 3));
      if (prev_stall) begin
        chk("stall_hold_blk", u_if.block_out, held);
        chk("stall_hold_idx", W'(u_if.idx_out), W'(held_idx));
      end
      held       = u_if.block_out;
      held_idx   = u_if.idx_out;
      prev_stall = !u_if.ready_out;
      if (u_if.ready_out) begin
        xfers++;
        k++;
      end
      cyc++;
    end
    chk("stall_xfers", W'(xfers), W'(4));
    @(negedge clock);
    u_if.ready_out = 1'b1;
    #1;
    chk("stall_idle", W'(u_if.valid_out), W'(1'b0));

    // two 4:2:0 blocks back to back
    @(negedge clock);
    offer(2'd1, 2'd2, ramp);
    u_if.ready_out = 1'b1;
    #1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clock);
      if (b <= 3) offer(2'd1, 2'd2, ramp2);
      else u_if.valid_in = 1'b0;
      #1;
      chk($sformatf("b2b_valid_%0d", b), W'(u_if.valid_out), W'(1'b1));
      chk($sformatf("b2b_idx_%0d", b), W'(u_if.idx_out), W'(b % 4));
      chk($sformatf("b2b_last_%0d", b), W'(u_if.last_out), W'(b % 4 == 3));
      chk($sformatf("b2b_ready_in_%0d", b), W'(u_if.ready_in), W'(b == 3 || b == 7));
      chk($sformatf("b2b_blk_%0d", b), u_if.block_out, exp_blk((b < 4) ? ramp : ramp2, 4, b % 4));
    end
    @(negedge clock);
    #1;
    chk("b2b_idle", W'(u_if.valid_out), W'(1'b0));

    // reset during beat 2
    @(negedge clock);
    offer(2'd1, 2'd2, ramp);
    u_if.ready_out = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clock);
      u_if.valid_in = 1'b0;
      #1;
      chk("pre_rst_idx", W'(u_if.idx_out), W'(b));
    end
    @(negedge clock);
    #1;
    chk("pre_rst_idx2", W'(u_if.idx_out), W'(2));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", W'(u_if.valid_out), W'(1'b0));
    chk("mid_rst_block", u_if.block_out, W'(0));
    chk("mid_rst_ready_in", W'(u_if.ready_in), W'(1'b1));
    chk("mid_rst_idx", W'(u_if.idx_out), W'(2'd0));
    chk("mid_rst_last", W'(u_if.last_out), W'(1'b0));
    chk("mid_rst_ch", W'(u_if.ch_out), W'(2'd0));
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_idle", W'(u_if.valid_out), W'(1'b0));
    run_block(2'd0, 2'd0, ramp2, 1);
    chk("post_rst_y", seen[0], ramp2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chroma_upsampler.md
# chroma_upsampler

Sequential, parametrised chroma upsampler between the IDCT/dequant output and the colour-conversion stage. It accepts one decoded 8x8 component block per handshake and registers it. It then streams 1, 2 or 4 nearest-neighbour upsampled 8x8 blocks, one per output handshake, according to the per-block sampling mode. Luma and 4:4:4 chroma pass straight through as a single beat, with full valid/ready backpressure on both sides.

## Interface
- PIX_W, default 8: sample width in bits.
- BLK, default 8: block edge in samples; must be even and at least 4.
- clock  in  1: single clock, all state on rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- ch  in  $clog2(`CH+1): component of the input block (0 = Y, 1 = Cb, 2 = Cr).
- mode  in  2: sampling mode, sampled with the block (0 = 4:4:4, 1 = 4:2:2, 2 = 4:2:0, 3 = reserved).
- valid_in  in  1: input block valid.
- ready_in  out  1: block accepted when valid_in && ready_in.
- block_in  in  PIX_W x [BLK][BLK]: input samples, indexed [row][col].
- valid_out  out  1: output block valid.
- ready_out  in  1: downstream ready; a beat transfers when valid_out && ready_out.
- block_out  out  PIX_W x [BLK][BLK]: upsampled output block.
- ch_out  out  $clog2(`CH+1): ch of the source block.
- idx_out  out  2: sub-block index of the current beat.
- last_out  out  1: final beat of the current source block.

## Operation
- Beat count N per block:
  - ch == 0, mode 0, or mode 3: N = 1.
  - ch in {1, 2} and mode 1: N = 2.
  - ch in {1, 2} and mode 2: N = 4.
  - ch == 3: N = 1.
- Let H = BLK/2.
- N = 1 mapping: out[i][j] = in[i][j].
- 4:2:2 mapping, beat k in 0..1: out[i][j] = in[i][k*H + j/2]. Beat 0 is the left half, beat 1 is the right half.
- 4:2:0 mapping, beat k in 0..3, with r = k[1] and c = k[0]: out[i][j] = in[r*H + i/2][c*H + j/2]. Order is top-left, top-right, bottom-left, bottom-right.
- Integer division truncates. No arithmetic on sample values; samples are copied bit-exactly.
- FSM states:
  - IDLE: ready_in = 1, valid_out = 0.
    - On accept, capture block_in, ch and mode into the source register, set beat = 0, compute N, and go to EMIT.
  - EMIT: valid_out = 1.
    - Outputs are a function of the source register and beat; idx_out = beat, last_out = (beat == N-1).
    - Handshake on a non-last beat: beat increments.
    - Handshake on the last beat: if valid_in is high the next block is captured in that same cycle and the FSM stays in EMIT with beat = 0; otherwise the FSM returns to IDLE.
- ready_in = IDLE || (EMIT && last_out && ready_out). This gives back-to-back blocks with no bubble.
- Inputs (ch, mode, block_in) are ignored unless an accept occurs.

## Timing
- Reset values (asynchronous, while reset_n = 0):
  - State = IDLE, beat = 0.
  - valid_out = 0, ready_in = 1, last_out = 0, idx_out = 0, ch_out = 0.
  - block_out = all zeros.
- Latency: a block accepted at edge T is presented on block_out with valid_out = 1 from edge T+1.
- Sustained throughput: one beat per cycle while ready_out = 1. A 4:2:0 chroma block therefore occupies 4 cycles.
- Stall (ready_out = 0): block_out, idx_out, last_out and ch_out hold stable; beat does not advance; ready_in = 0.
- valid_out never drops while a beat is pending, which is AXI-style persistence.
- Reset asserted mid-block: the partial block is discarded and outputs return to reset values immediately. The first cycle after deassertion is in IDLE.
- valid_in while in EMIT on a non-last beat: not accepted, since ready_in = 0. Upstream must hold the block.

## Structure
- Package jpeg_upsample_pkg:
  - typedef pix_t (logic [PIX_W-1:0]) and block_t (pix_t [BLK][BLK]).
  - enum samp_mode_t {SAMP_444, SAMP_422, SAMP_420, SAMP_RSVD}.
  - enum ups_state_t {UPS_IDLE, UPS_EMIT}.
  - Function beats_for(ch, mode).
- Sub-module upsample_map: purely combinational. Inputs are the source block, mode, N and beat; output is the mapped block. It holds all indexing so the FSM module carries only control and registers.
- The output block is driven combinationally from the registered source through upsample_map. No extra output register is used, so latency stays at 1.

## Test plan
- Reset, then a Y block with in[i][j] = 8*i + j and mode 2, ready_out = 1 → single beat at T+1 with idx 0 and last 1; out equals in; FSM back to IDLE.
- Cb block with in[i][j] = 8*i + j, mode 2 → 4 beats, idx 0..3. Beat 0 has out[0][0] = out[1][1] = 0 and out[7][7] = 27. Beat 3 has out[0][0] = 36 and out[7][7] = 63. last_out only on beat 3.
- Cr block, mode 1, same data → 2 beats. Beat 0 has out[5][7] = 43 and beat 1 has out[5][7] = 47; idx_out = 0, 1.
- 4:2:0 Cb with ready_out toggling 1, 0, 0, 1, ... → output held bit-stable through stalls; exactly 4 transfers; ready_in = 0 until the last transfer.
- Two Cb 4:2:0 blocks offered back-to-back with ready_out = 1 → 8 consecutive beats with no idle cycle; the second block is accepted on the cycle of the first block's beat 3.
- reset_n pulsed low during beat 2 of a 4:2:0 block → valid_out = 0 and block_out = 0 immediately. After release, a new Y block is emitted correctly with idx 0.
